instr_fetch_unit: RTL and testbench

//  Consumes the program-counter stream and fetches instructions from instruction memory.

---
 rtl/instr_fetch_unit.sv | 114 +++++++++++
 tb/tb_instr_fetch_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC sequencer, in-order imem request/response tracking,
// and a small {pc, instr} queue feeding decode. Redirects flush and drop in-flight work.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       INSTR_W  = 16,
  parameter int unsigned       QDEPTH   = 2,
  parameter int unsigned       PC_STEP  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req_valid,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               ifq_valid,
  output logic [INSTR_W-1:0] ifq_instr,
  output logic [ADDR_W-1:0]  ifq_pc,
  input  logic               ifq_ready
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam int unsigned SW = CW + 2;

  logic               r_reset_q;
  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [CW-1:0]      r_inflight;
  logic [CW-1:0]      r_drop;
  logic [ADDR_W-1:0]  r_pcf [QDEPTH];
  logic [PW-1:0]      r_pcf_wr;
  logic [PW-1:0]      r_pcf_rd;
  logic [ADDR_W-1:0]  r_q_pc [QDEPTH];
  logic [INSTR_W-1:0] r_q_instr [QDEPTH];
  logic [PW-1:0]      r_q_wr;
  logic [PW-1:0]      r_q_rd;
  logic [CW-1:0]      r_q_count;

  logic [SW-1:0]      w_credit_sum;
  logic               w_req_fire;
  logic               w_rsp_drop;
  logic               w_rsp_take;
  logic               w_push;
  logic               w_pop;
  logic [CW-1:0]      w_drop_redir;

  always_comb begin
    w_credit_sum   = SW'(r_q_count) + SW'(r_inflight) + SW'(r_drop);
    imem_req_valid = !r_reset_q && !redirect_valid && (w_credit_sum < SW'(QDEPTH));
    imem_req_addr  = r_fetch_pc;
    w_req_fire     = imem_req_valid && imem_req_ready;
    w_rsp_drop     = imem_rsp_valid && (r_drop != '0);
    w_rsp_take     = imem_rsp_valid && (r_drop == '0) && (r_inflight != '0);
    w_push         = w_rsp_take && !redirect_valid && !reset;
    ifq_valid      = (r_q_count != '0);
    w_pop          = ifq_valid && ifq_ready;
    ifq_instr      = ifq_valid ? r_q_instr[r_q_rd] : '0;
    ifq_pc         = ifq_valid ? r_q_pc[r_q_rd] : '0;
    // Everything still owed by memory becomes a drop, minus the response retired this cycle
    w_drop_redir   = CW'(SW'(r_drop) + SW'(r_inflight) - SW'(w_rsp_drop || w_rsp_take));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_reset_q  <= 1'b1;
      r_fetch_pc <= RESET_PC;
      r_inflight <= '0;
      r_drop     <= '0;
      r_pcf_wr   <= '0;
      r_pcf_rd   <= '0;
      r_q_wr     <= '0;
      r_q_rd     <= '0;
      r_q_count  <= '0;
    end else begin
      r_reset_q <= 1'b0;
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc;
        r_drop     <= w_drop_redir;
        r_inflight <= '0;
        r_pcf_wr   <= '0;
        r_pcf_rd   <= '0;
        r_q_wr     <= '0;
        r_q_rd     <= '0;
        r_q_count  <= '0;
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
          r_pcf_wr   <= r_pcf_wr + PW'(1);
        end
        if (w_rsp_take) r_pcf_rd <= r_pcf_rd + PW'(1);
        if (w_rsp_drop) r_drop <= r_drop - CW'(1);
        r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_rsp_take);
        if (w_push) r_q_wr <= r_q_wr + PW'(1);
        if (w_pop)  r_q_rd <= r_q_rd + PW'(1);
        r_q_count <= r_q_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_fire) r_pcf[r_pcf_wr] <= r_fetch_pc;
    if (w_push) begin
      r_q_pc[r_q_wr]    <= r_pcf[r_pcf_rd];
      r_q_instr[r_q_wr] <= imem_rsp_data;
    end
  end

  a_credit_bound: assert property (@(posedge clk) disable iff (reset)
    (w_credit_sum <= SW'(QDEPTH)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit: a memory model, a fetch-order
// reference and a decoupled monitor that checks every decode handshake.
module tb_instr_fetch_unit;

  localparam int unsigned QDEPTH   = 2;
  localparam int unsigned PC_STEP  = 1;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req_valid;
  logic [15:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        ifq_valid;
  logic [15:0] ifq_instr;
  logic [15:0] ifq_pc;
  logic        ifq_ready;

  instr_fetch_unit #(
    .ADDR_W   (16),
    .INSTR_W  (16),
    .QDEPTH   (QDEPTH),
    .PC_STEP  (PC_STEP),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .ifq_valid      (ifq_valid),
    .ifq_instr      (ifq_instr),
    .ifq_pc         (ifq_pc),
    .ifq_ready      (ifq_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference state: fetched-but-not-consumed PCs in order, how many of them have data,
  // responses owed by memory, and how many of those belong to a flushed stream.
  logic [15:0] exp_q[$];
  int          arrived_cnt = 0;
  logic [15:0] pend_addr[$];
  int          pend_due[$];
  int          stale_cnt = 0;
  logic [15:0] model_pc = RESET_PC;
  bit          tb_rst_q = 1'b1;
  bit          rst_prev = 1'b0;
  bit          mon_en   = 1'b0;

  int unsigned p_rdy = 100, p_ifq = 100, p_rsp = 100, p_redir = 0, p_spur = 0, p_rst_pm = 0;
  int unsigned max_lat = 1;
  int          force_rst = 0;
  bit          force_redir = 1'b0;
  logic [15:0] redir_target = '0;
  bit          redir_rsp_pop = 1'b0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic run(input int n);
    bit exp_rv;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc++;
      reset = (force_rst > 0) || ($urandom_range(0, 999) < p_rst_pm);
      if (force_rst > 0) force_rst--;
      imem_req_ready = ($urandom_range(0, 99) < p_rdy);
      ifq_ready      = ($urandom_range(0, 99) < p_ifq);
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 16'($urandom);
      if (pend_addr.size() > 0) begin
        if (pend_due[0] <= cyc && $urandom_range(0, 99) < p_rsp) begin
          imem_rsp_valid = 1'b1;
          if (stale_cnt == 0) imem_rsp_data = mem_word(pend_addr[0]);
        end
      end else if ($urandom_range(0, 99) < p_spur) begin
        imem_rsp_valid = 1'b1;
      end
      redirect_valid = 1'b0;
      redirect_pc    = 16'($urandom);
      if (!reset) begin
        if (force_redir) begin
          redirect_valid = 1'b1;
          redirect_pc    = redir_target;
          force_redir    = 1'b0;
        end else if (redir_rsp_pop && imem_rsp_valid && ifq_valid) begin
          redirect_valid = 1'b1;
          ifq_ready      = 1'b1;
        end else if ($urandom_range(0, 99) < p_redir) begin
          redirect_valid = 1'b1;
        end
      end
      exp_rv = !tb_rst_q && !redirect_valid && ((exp_q.size() + stale_cnt) < QDEPTH);
      #2;
      if (reset) begin
        if (rst_prev) begin
          check("rst_ifq_valid", 32'(ifq_valid), 32'(0));
          check("rst_req_valid", 32'(imem_req_valid), 32'(0));
          check("rst_ifq_instr", 32'(ifq_instr), 32'(0));
          check("rst_ifq_pc", 32'(ifq_pc), 32'(0));
          check("rst_req_addr", 32'(imem_req_addr), 32'(RESET_PC));
          mon_en = 1'b1;
        end
        exp_q.delete();
        arrived_cnt = 0;
        pend_addr.delete();
        pend_due.delete();
        stale_cnt = 0;
        model_pc  = RESET_PC;
        tb_rst_q  = 1'b1;
        rst_prev  = 1'b1;
      end else begin
        rst_prev = 1'b0;
        if (mon_en) begin
          check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
          if (imem_req_valid) check("req_addr", 32'(imem_req_addr), 32'(model_pc));
        end
        if (imem_rsp_valid && pend_addr.size() > 0) begin
          void'(pend_addr.pop_front());
          void'(pend_due.pop_front());
          if (stale_cnt > 0) stale_cnt--;
          else arrived_cnt++;
        end
        if (imem_req_valid && imem_req_ready) begin
          exp_q.push_back(model_pc);
          pend_addr.push_back(model_pc);
          pend_due.push_back(cyc + int'($urandom_range(1, max_lat)));
          model_pc = model_pc + 16'(PC_STEP);
        end
        if (redirect_valid) begin
          stale_cnt   = pend_addr.size();
          exp_q.delete();
          arrived_cnt = 0;
          model_pc    = redirect_pc;
        end
        tb_rst_q = 1'b0;
      end
    end
  endtask

  // Monitor: pops the expected stream whenever decode takes the head.
  initial begin
    logic [15:0] mpc;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        check("ifq_valid", 32'(ifq_valid), 32'(arrived_cnt > 0));
        if (ifq_valid && ifq_ready && arrived_cnt > 0) begin
          mpc = exp_q.pop_front();
          arrived_cnt--;
          check("ifq_pc", 32'(ifq_pc), 32'(mpc));
          check("ifq_instr", 32'(ifq_instr), 32'(mem_word(mpc)));
        end
      end
    end
  end

  task automatic drain();
    p_rdy = 0; p_rsp = 100; p_ifq = 100;
    run(6);
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; ifq_ready = 1'b0;

    force_rst = 3;
    run(3);

    // T1: streaming, one-cycle memory
    run(40);

    // T2: decode stalls, credit limits requests, then resumes
    drain();
    force_rst = 2; run(2);
    p_rdy = 100; p_ifq = 0; run(10);
    p_ifq = 100; run(10);

    // T3: memory not ready at 0005
    drain();
    redir_target = 16'h0005; force_redir = 1'b1; run(1);
    p_rdy = 0; run(3);
    p_rdy = 100; run(10);

    // T4: two in flight, redirect drops both
    drain();
    p_rsp = 0; p_rdy = 100;
    redir_target = 16'h0010; force_redir = 1'b1; run(1);
    for (int i = 0; i < 20 && pend_addr.size() < 2; i++) run(1);
    check("t4_two_inflight", 32'(pend_addr.size()), 32'(2));
    redir_target = 16'h0040; force_redir = 1'b1; run(1);
    p_rsp = 100; run(12);

    // T5: redirect colliding with a response and a pop
    p_ifq = 50; max_lat = 2; redir_rsp_pop = 1'b1;
    run(60);
    redir_rsp_pop = 1'b0; max_lat = 1;

    // T6: address wrap, then reset with two in flight and stray responses
    drain();
    p_rdy = 100;
    redir_target = 16'hFFFE; force_redir = 1'b1; run(1);
    run(6);
    p_rsp = 0;
    for (int i = 0; i < 20 && pend_addr.size() < 2; i++) run(1);
    check("t6_two_inflight", 32'(pend_addr.size()), 32'(2));
    force_rst = 2; p_spur = 60; p_rsp = 100;
    run(15);

    // Random mix
    p_rdy = 70; p_ifq = 60; p_rsp = 70; p_redir = 5; p_spur = 10; p_rst_pm = 5; max_lat = 4;
    run(2500);

    p_redir = 0; p_rst_pm = 0; p_spur = 0;
    run(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
